// File: rtl/microstore_sequencer_pkg.sv
// Shared sequencing codes and default vectors for the microstore sequencer.
// The microcode assembler mirrors these ns_sel/cond_sel encodings.
package microstore_sequencer_pkg;

  typedef enum logic [2:0] {
    NS_ENC   = 3'b000,
    NS_FETCH = 3'b001,
    NS_JUMP  = 3'b010,
    NS_INC   = 3'b011,
    NS_CJMP  = 3'b100,
    NS_CWAIT = 3'b101,
    NS_CALL  = 3'b110,
    NS_RET   = 3'b111
  } ns_sel_e;

  typedef enum logic [1:0] {
    CS_MOC  = 2'd0,
    CS_COND = 2'd1,
    CS_ZERO = 2'd2,
    CS_ONE  = 2'd3
  } cs_sel_e;

  localparam int DEF_FETCH_VEC = 0;
  localparam int DEF_UNDEF_VEC = 90;
  localparam int DEF_ABORT_VEC = 91;

endpackage

// File: rtl/microstore_sequencer_cond_mux.sv
// Condition select for conditional sequencing: 4:1 status mux plus optional inversion.
// Purely combinational.
module microstore_sequencer_cond_mux
  import microstore_sequencer_pkg::*;
(
  input  logic [1:0] cond_sel,
  input  logic       inv,
  input  logic       moc,
  input  logic       cond_true,
  input  logic       zero,
  output logic       c
);

  logic sel;

  always_comb begin
    sel = 1'b1;
    unique case (cs_sel_e'(cond_sel))
      CS_MOC:  sel = moc;
      CS_COND: sel = cond_true;
      CS_ZERO: sel = zero;
      CS_ONE:  sel = 1'b1;
      default: sel = 1'b1;
    endcase
  end

  assign c = sel ^ inv;

endmodule

// File: rtl/microstore_sequencer.sv
// Next-index register for the microprogrammed control unit, feeding the microstore ROM.
// Optional CWAIT watchdog is built only when MOC_WATCHDOG_EN is defined.
//
// ns_sel | meaning
// ENC    | enc_valid ? enc_addr : UNDEF_VEC
// FETCH  | FETCH_VEC
// JUMP   | cr_addr
// INC    | index+1 (wraps)
// CJMP   | c ? cr_addr : index+1
// CWAIT  | c ? index+1 : hold (watchdog may force ABORT_VEC)
// CALL   | cr_addr, ret <= index+1
// RET    | ret
module microstore_sequencer
  import microstore_sequencer_pkg::*;
#(
  parameter int AW          = 7,
  parameter int FETCH_VEC   = DEF_FETCH_VEC,
  parameter int UNDEF_VEC   = DEF_UNDEF_VEC,
  parameter int ABORT_VEC   = DEF_ABORT_VEC,
  parameter int MOC_TIMEOUT = 16,
  parameter int TW          = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    ns_sel,
  input  logic [1:0]    cond_sel,
  input  logic          inv,
  input  logic [AW-1:0] cr_addr,
  input  logic [AW-1:0] enc_addr,
  input  logic          enc_valid,
  input  logic          moc,
  input  logic          cond_true,
  input  logic          zero,
  output logic [AW-1:0] index,
  output logic          moc_timeout
);

  localparam logic [AW-1:0] FETCH_IDX = AW'(FETCH_VEC);
  localparam logic [AW-1:0] UNDEF_IDX = AW'(UNDEF_VEC);
  localparam logic [AW-1:0] ABORT_IDX = AW'(ABORT_VEC);

  // A counter that cannot reach MOC_TIMEOUT-1 would silently disable the abort.
  if (MOC_TIMEOUT < 2 || TW < 1 || (2 ** TW) <= MOC_TIMEOUT) begin : g_bad_cfg
    $error("microstore_sequencer: need MOC_TIMEOUT >= 2 and 2**TW > MOC_TIMEOUT");
  end

  ns_sel_e       ns_cur;
  logic          c;
  logic          wd_expired;
  logic [AW-1:0] inc;
  logic [AW-1:0] index_q, index_d;
  logic [AW-1:0] ret_q, ret_d;

  assign ns_cur = ns_sel_e'(ns_sel);
  assign inc    = index_q + AW'(1);

  microstore_sequencer_cond_mux u_cond_mux (
    .cond_sel  (cond_sel),
    .inv       (inv),
    .moc       (moc),
    .cond_true (cond_true),
    .zero      (zero),
    .c         (c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q <= FETCH_IDX;
      ret_q   <= '0;
    end else begin
      index_q <= index_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    index_d = index_q;
    ret_d   = ret_q;
    unique case (ns_cur)
      NS_ENC:   index_d = enc_valid ? enc_addr : UNDEF_IDX;
      NS_FETCH: index_d = FETCH_IDX;
      NS_JUMP:  index_d = cr_addr;
      NS_INC:   index_d = inc;
      NS_CJMP:  index_d = c ? cr_addr : inc;
      NS_CWAIT: begin
        if (c)               index_d = inc;
        else if (wd_expired) index_d = ABORT_IDX;
        else                 index_d = index_q;
      end
      NS_CALL: begin
        index_d = cr_addr;
        ret_d   = inc;
      end
      NS_RET:   index_d = ret_q;
      default:  index_d = index_q;
    endcase
  end

  assign index = index_q;

`ifdef MOC_WATCHDOG_EN
  localparam logic [TW-1:0] WD_LAST = TW'(MOC_TIMEOUT - 1);

  logic          waiting;
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic          moc_timeout_q, moc_timeout_d;

  assign waiting    = (ns_cur == NS_CWAIT) && !c;
  assign wd_expired = waiting && (wd_cnt_q == WD_LAST);

  always_comb begin
    wd_cnt_d      = '0;
    moc_timeout_d = wd_expired;
    if (waiting && !wd_expired) wd_cnt_d = wd_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q      <= '0;
      moc_timeout_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      moc_timeout_q <= moc_timeout_d;
    end
  end

  assign moc_timeout = moc_timeout_q;
`else
  assign wd_expired  = 1'b0;
  assign moc_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_microstore_sequencer.sv
// Directed bench for microstore_sequencer: vector table plus CWAIT/watchdog/reset sequences.
module tb_microstore_sequencer;
  import microstore_sequencer_pkg::*;

  typedef struct {
    logic [2:0] ns;
    logic [1:0] cs;
    logic       iv;
    logic [6:0] cr;
    logic [6:0] ea;
    logic       ev;
    logic       m;
    logic       ct;
    logic       z;
    logic [6:0] exp_idx;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] ns_sel;
  logic [1:0] cond_sel;
  logic       inv;
  logic [6:0] cr_addr;
  logic [6:0] enc_addr;
  logic       enc_valid;
  logic       moc;
  logic       cond_true;
  logic       zero;
  logic [6:0] index;
  logic       moc_timeout;

  int errors = 0;
  int checks = 0;
  vec_t vt[21];

  always #5 clk = ~clk;

  microstore_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ns_sel      (ns_sel),
    .cond_sel    (cond_sel),
    .inv         (inv),
    .cr_addr     (cr_addr),
    .enc_addr    (enc_addr),
    .enc_valid   (enc_valid),
    .moc         (moc),
    .cond_true   (cond_true),
    .zero        (zero),
    .index       (index),
    .moc_timeout (moc_timeout)
  );

  function automatic vec_t mk(logic [2:0] ns, logic [1:0] cs, logic iv, logic [6:0] cr,
                              logic [6:0] ea, logic ev, logic m, logic ct, logic z,
                              logic [6:0] e);
    vec_t v;
    v.ns = ns; v.cs = cs; v.iv = iv; v.cr = cr; v.ea = ea; v.ev = ev;
    v.m = m; v.ct = ct; v.z = z; v.exp_idx = e;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    ns_sel = v.ns; cond_sel = v.cs; inv = v.iv; cr_addr = v.cr;
    enc_addr = v.ea; enc_valid = v.ev; moc = v.m; cond_true = v.ct; zero = v.z;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [6:0] target);
    apply(mk(NS_JUMP, CS_ONE, 1'b0, target, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, target));
    step();
  endtask

  initial begin
    //            ns        cs      iv  cr   ea  ev  m  ct z  exp
    vt[0]  = mk(NS_JUMP,  CS_ONE,  0, 5,   0,  0, 0, 0, 0, 5);
    vt[1]  = mk(NS_CJMP,  CS_COND, 0, 20,  0,  0, 0, 1, 0, 20);
    vt[2]  = mk(NS_JUMP,  CS_ONE,  0, 5,   0,  0, 0, 0, 0, 5);
    vt[3]  = mk(NS_CJMP,  CS_COND, 1, 20,  0,  0, 0, 1, 0, 6);
    vt[4]  = mk(NS_ENC,   CS_ONE,  0, 0,   42, 1, 0, 0, 0, 42);
    vt[5]  = mk(NS_ENC,   CS_ONE,  0, 0,   42, 0, 0, 0, 0, 90);
    vt[6]  = mk(NS_JUMP,  CS_ONE,  0, 127, 0,  0, 0, 0, 0, 127);
    vt[7]  = mk(NS_INC,   CS_ONE,  0, 0,   0,  0, 0, 0, 0, 0);
    vt[8]  = mk(NS_JUMP,  CS_ONE,  0, 10,  0,  0, 0, 0, 0, 10);
    vt[9]  = mk(NS_CALL,  CS_ONE,  0, 80,  0,  0, 0, 0, 0, 80);
    vt[10] = mk(NS_RET,   CS_ONE,  0, 0,   0,  0, 0, 0, 0, 11);
    vt[11] = mk(NS_CJMP,  CS_ZERO, 0, 33,  0,  0, 0, 0, 1, 33);
    vt[12] = mk(NS_CJMP,  CS_ZERO, 0, 50,  0,  0, 0, 0, 0, 34);
    vt[13] = mk(NS_CJMP,  CS_ONE,  1, 60,  0,  0, 0, 0, 0, 35);
    vt[14] = mk(NS_CJMP,  CS_MOC,  0, 70,  0,  0, 1, 0, 0, 70);
    vt[15] = mk(NS_FETCH, CS_ONE,  0, 99,  0,  0, 0, 0, 0, 0);
    vt[16] = mk(NS_JUMP,  CS_ONE,  0, 127, 0,  0, 0, 0, 0, 127);
    vt[17] = mk(NS_CALL,  CS_ONE,  0, 3,   0,  0, 0, 0, 0, 3);
    vt[18] = mk(NS_RET,   CS_ONE,  0, 0,   0,  0, 0, 0, 0, 0);
    vt[19] = mk(NS_CWAIT, CS_COND, 0, 0,   0,  0, 0, 1, 0, 1);
    vt[20] = mk(NS_CWAIT, CS_ZERO, 0, 0,   0,  0, 0, 0, 1, 2);

    reset_n = 1'b0;
    apply(mk(NS_INC, CS_ONE, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0));
    #2;
    check("reset index", index, 0);
    check("reset moc_timeout", moc_timeout, 0);
    #10 reset_n = 1'b1;
    #1;

    for (int i = 0; i < 21; i++) begin
      apply(vt[i]);
      step();
      check($sformatf("vec%0d index", i), index, vt[i].exp_idx);
      check($sformatf("vec%0d moc_timeout", i), moc_timeout, 0);
    end

    // CWAIT holds while moc is low, advances on moc
    jump(7'd3);
    apply(mk(NS_CWAIT, CS_MOC, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd3));
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("cwait hold%0d", k), index, 3);
    end
    moc = 1'b1;
    step();
    check("cwait release", index, 4);

    // watchdog expiry (or indefinite hold without the watchdog)
    jump(7'd3);
    apply(mk(NS_CWAIT, CS_MOC, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd3));
    for (int k = 1; k <= 15; k++) begin
      step();
      check($sformatf("wd wait%0d index", k), index, 3);
      check($sformatf("wd wait%0d moc_timeout", k), moc_timeout, 0);
    end
    step();
`ifdef MOC_WATCHDOG_EN
    check("wd abort index", index, 91);
    check("wd abort pulse", moc_timeout, 1);
    apply(mk(NS_INC, CS_ONE, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd92));
    step();
    check("wd after abort index", index, 92);
    check("wd pulse one cycle", moc_timeout, 0);
`else
    for (int k = 0; k < 100; k++) step();
    check("no wd long hold index", index, 3);
    check("no wd moc_timeout", moc_timeout, 0);
`endif

    // moc arriving on the 16th edge wins over the abort
    jump(7'd3);
    apply(mk(NS_CWAIT, CS_MOC, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd3));
    for (int k = 1; k <= 15; k++) step();
    check("wd edge15 index", index, 3);
    moc = 1'b1;
    step();
    check("wd late moc index", index, 4);
    check("wd late moc no pulse", moc_timeout, 0);

    // async reset mid-CWAIT with a live return address
    jump(7'd10);
    apply(mk(NS_CALL, CS_ONE, 1'b0, 7'd80, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd80));
    step();
    check("pre-reset call", index, 80);
    jump(7'd3);
    apply(mk(NS_CWAIT, CS_MOC, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd3));
    for (int k = 0; k < 5; k++) step();
    check("pre-reset hold", index, 3);
    #2 reset_n = 1'b0;
    #1;
    check("async reset index", index, 0);
    check("async reset moc_timeout", moc_timeout, 0);
    #2 reset_n = 1'b1;
    apply(mk(NS_RET, CS_ONE, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0));
    step();
    check("ret cleared by reset", index, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
